// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-buffered UART peripheral: register map,
// STATUS/CTRL bit positions, FSM state types and the divisor floor.
package uart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_DIV    = 2'd3;

  localparam int unsigned ST_TX_FULL   = 0;
  localparam int unsigned ST_TX_EMPTY  = 1;
  localparam int unsigned ST_RX_FULL   = 2;
  localparam int unsigned ST_RX_EMPTY  = 3;
  localparam int unsigned ST_TX_OVF    = 4;
  localparam int unsigned ST_RX_OVF    = 5;
  localparam int unsigned ST_FRAME_ERR = 6;
  localparam int unsigned ST_TX_BUSY   = 7;

  localparam int unsigned CTRL_RX_IE  = 0;
  localparam int unsigned CTRL_TX_IE  = 1;
  localparam int unsigned CTRL_ERR_IE = 2;

  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers. A pop on empty is ignored; a push
// on full is accepted only when a pop frees a slot in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_periph.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, runtime baud divisor, sticky
// error flags and a registered level interrupt.
module uart_fifo_periph
  import uart_pkg::*;
#(
  parameter int unsigned TX_DEPTH  = 16,
  parameter int unsigned RX_DEPTH  = 16,
  parameter int unsigned DIV_RESET = 104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wstrb,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  logic        access, status_wr;
  logic [2:0]  ctrl;
  logic [15:0] div, div_next;
  logic        tx_ovf, rx_ovf, frame_err;
  logic [7:0]  status;

  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_rdata;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_rdata;
  logic [$clog2(TX_DEPTH):0] unused_tx_count;
  logic [$clog2(RX_DEPTH):0] unused_rx_count;
  logic        unused_bus_bits;

  tx_state_t   tx_state;
  logic [15:0] tx_div, tx_cnt;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_bit;
  logic        tx_bit_end;

  rx_state_t   rx_state;
  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] rx_div, rx_cnt;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_bit;
  logic        rx_bit_end, rx_half_hit, rx_stop_sample;

  assign unused_bus_bits = ^{bus_wdata[31:16], bus_wstrb[3:2]};

  // Acceptance is blocked while bus_ready is high so a held select cannot repeat a side effect.
  assign access    = bus_sel && !bus_ready;
  assign tx_push   = access && bus_we && (bus_addr == ADDR_DATA) && bus_wstrb[0];
  assign rx_pop    = access && !bus_we && (bus_addr == ADDR_DATA);
  assign status_wr = access && bus_we && (bus_addr == ADDR_STATUS) && bus_wstrb[0];
  assign div_next  = {bus_wstrb[1] ? bus_wdata[15:8] : div[15:8],
                      bus_wstrb[0] ? bus_wdata[7:0]  : div[7:0]};

  uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(bus_wdata[7:0]),
    .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(unused_tx_count)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(rx_shift),
    .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(unused_rx_count)
  );

  always_comb begin
    status               = '0;
    status[ST_TX_FULL]   = tx_full;
    status[ST_TX_EMPTY]  = tx_empty;
    status[ST_RX_FULL]   = rx_full;
    status[ST_RX_EMPTY]  = rx_empty;
    status[ST_TX_OVF]    = tx_ovf;
    status[ST_RX_OVF]    = rx_ovf;
    status[ST_FRAME_ERR] = frame_err;
    status[ST_TX_BUSY]   = (tx_state != TX_IDLE) || !tx_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_ready <= 1'b0;
      bus_rdata <= '0;
      ctrl      <= '0;
      div       <= 16'(DIV_RESET);
    end else begin
      bus_ready <= access;
      if (access) begin
        bus_rdata <= '0;
        if (!bus_we) begin
          case (bus_addr)
            ADDR_DATA:   bus_rdata <= rx_empty ? 32'h8000_0000 : {24'b0, rx_rdata};
            ADDR_STATUS: bus_rdata <= {24'b0, status};
            ADDR_CTRL:   bus_rdata <= {29'b0, ctrl};
            default:     bus_rdata <= {16'b0, div};
          endcase
        end else if (bus_addr == ADDR_CTRL && bus_wstrb[0]) begin
          ctrl <= bus_wdata[2:0];
        end else if (bus_addr == ADDR_DIV && (|bus_wstrb[1:0])) begin
          div <= clamp_div(div_next);
        end
      end
    end
  end

  // Setting wins over a simultaneous write-one-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
      frame_err <= 1'b0;
      irq       <= 1'b0;
    end else begin
      tx_ovf    <= (tx_push && tx_full && !tx_pop) ||
                   (tx_ovf && !(status_wr && bus_wdata[ST_TX_OVF]));
      rx_ovf    <= (rx_push && rx_full && !rx_pop) ||
                   (rx_ovf && !(status_wr && bus_wdata[ST_RX_OVF]));
      frame_err <= (rx_stop_sample && !rx_s2) ||
                   (frame_err && !(status_wr && bus_wdata[ST_FRAME_ERR]));
      irq       <= (ctrl[CTRL_RX_IE] && !rx_empty) ||
                   (ctrl[CTRL_TX_IE] && tx_empty) ||
                   (ctrl[CTRL_ERR_IE] && (tx_ovf || rx_ovf || frame_err));
    end
  end

  assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
  assign tx_pop     = !tx_empty &&
                      ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_bit_end));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      uart_tx  <= 1'b1;
      tx_div   <= DIV_MIN;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
    end else begin
      tx_cnt <= tx_cnt + 16'd1;
      if (tx_pop) begin
        tx_state <= TX_START;
        uart_tx  <= 1'b0;
        tx_shift <= tx_rdata;
        tx_div   <= div;
        tx_cnt   <= '0;
      end else begin
        case (tx_state)
          TX_IDLE: tx_cnt <= '0;
          TX_START: if (tx_bit_end) begin
            tx_state <= TX_DATA;
            uart_tx  <= tx_shift[0];
            tx_bit   <= '0;
            tx_cnt   <= '0;
          end
          TX_DATA: if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_tx  <= tx_shift[1];
            end
          end
          TX_STOP: if (tx_bit_end) begin
            tx_state <= TX_IDLE;
            uart_tx  <= 1'b1;
            tx_cnt   <= '0;
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_bit_end     = (rx_cnt == rx_div - 16'd1);
  assign rx_half_hit    = (rx_cnt == (rx_div >> 1) - 16'd1);
  assign rx_stop_sample = (rx_state == RX_STOP) && rx_bit_end;
  assign rx_push        = rx_stop_sample && rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_div   <= DIV_MIN;
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      rx_cnt <= rx_cnt + 16'd1;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_div   <= div;
          end
        end
        RX_START: if (rx_half_hit) begin
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          rx_bit   <= '0;
          rx_cnt   <= '0;
        end
        RX_DATA: if (rx_bit_end) begin
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_cnt   <= '0;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
          else                rx_bit   <= rx_bit + 3'd1;
        end
        RX_STOP: if (rx_bit_end) begin
          rx_state <= rx_s2 ? RX_IDLE : RX_WAIT;
          rx_cnt   <= '0;
        end
        RX_WAIT: begin
          rx_cnt <= '0;
          if (rx_s2) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule
